// File: rtl/epp_gpu_regs.sv
// epp_gpu_regs: register-mapped target behind the EPP parallel-port bridge.
//
// Purpose:
//   Decodes the bridge's one-cycle ip_wr/ip_rd pulses into the following blocks:
//   - GPU argument registers.
//   - A command FIFO that feeds the GPU core.
//   - A status register.
//   - A byte-wide framebuffer access port, addressed by a pointer register.
//
// Address map:
//   0x00..ARG_REGS-1 ARG regs (R/W).
//   0x10 CMD:    a write pushes {opcode, ARG snapshot}; a read returns last_opcode.
//   0x11 STATUS: {min(count,15), gpu_busy, overflow, full, empty}.
//                Writing 1 to bit2 clears overflow.
//   0x12..0x14 PTR low/mid/high (R/W). Bits at or above FB_AW read as 0.
//   0x15 FBDATA: a pulse here starts a framebuffer access that waits for fb_ack.
//   Every other address reads 0x00, and writes to it are ignored.
//
// Ports:
//   clk, rst_n                             clock, asynchronous active-low reset
//   ip_addr, ip_do, ip_wr, ip_rd           bridge request side
//   ip_di, ip_do_rdy                       bridge response side (ip_do_rdy=0 while busy)
//   cmd_valid, cmd_opcode, cmd_args,
//   cmd_ready                              command FIFO head handshake to the GPU
//   gpu_busy                               GPU busy flag, reported in STATUS
//   fb_req, fb_we, fb_addr, fb_wdata,
//   fb_rdata, fb_ack                       framebuffer access port
//
// Configuration macro:
//   EPP_GPU_REGS_AUTOINC_EN: PTR advances by one after every completed FBDATA access.
module epp_gpu_regs #(
  parameter int ARG_REGS   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FB_AW      = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            ip_addr,
  input  logic [7:0]            ip_do,
  input  logic                  ip_wr,
  input  logic                  ip_rd,
  output logic [7:0]            ip_di,
  output logic                  ip_do_rdy,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_opcode,
  output logic [8*ARG_REGS-1:0] cmd_args,
  input  logic                  cmd_ready,
  input  logic                  gpu_busy,
  output logic                  fb_req,
  output logic                  fb_we,
  output logic [FB_AW-1:0]      fb_addr,
  output logic [7:0]            fb_wdata,
  input  logic [7:0]            fb_rdata,
  input  logic                  fb_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ARGW = 8 * ARG_REGS;
  localparam logic [AW-1:0] FIFO_ONE = 1;
  localparam logic [FB_AW-1:0] PTR_ONE = 1;

  typedef enum logic {S_IDLE, S_FB_WAIT} state_t;

  state_t           r_state;
  logic             r_rdy;
  logic [7:0]       r_ip_di;
  logic             r_fb_req;
  logic             r_fb_we;
  logic [FB_AW-1:0] r_fb_addr;
  logic [7:0]       r_fb_wdata;
  logic [FB_AW-1:0] r_ptr;
  logic [7:0]       r_arg [ARG_REGS];
  logic [7:0]       r_last_opcode;
  logic             r_overflow;
  logic [4:0]       r_count;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [7:0]       r_op_mem   [FIFO_DEPTH];
  logic [ARGW-1:0]  r_args_mem [FIFO_DEPTH];

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_fb_start;
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_empty;
  logic             w_full;
  logic [3:0]       w_cnt_sat;
  logic [7:0]       w_status;
  logic [ARGW-1:0]  w_args;
  logic [23:0]      w_ptr24;
  logic [FB_AW-1:0] w_ptr_wdata;
  logic             w_ptr_sel;
  logic [7:0]       w_rd_val;

  // Pulses are only honoured while idle. When ip_wr and ip_rd arrive together, the write wins.
  assign w_wr_ok    = ip_wr && r_rdy;
  assign w_rd_ok    = ip_rd && !ip_wr && r_rdy;
  assign w_fb_start = (ip_wr || ip_rd) && r_rdy && (ip_addr == 8'h15);

  // FIFO control. A pop can only happen when the FIFO is non-empty.
  // As a result, a push and a pop on an empty FIFO simply yields count = 1.
  assign w_empty   = (r_count == 5'd0);
  assign w_full    = (r_count == 5'(FIFO_DEPTH));
  assign w_push    = w_wr_ok && (ip_addr == 8'h10);
  assign w_pop     = !w_empty && cmd_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_cnt_sat = (r_count > 5'd15) ? 4'hF : r_count[3:0];
  assign w_status  = {w_cnt_sat, gpu_busy, r_overflow, w_full, w_empty};

  assign cmd_valid  = !w_empty;
  assign cmd_opcode = r_op_mem[r_rd_ptr];
  assign cmd_args   = r_args_mem[r_rd_ptr];

  assign ip_di     = r_ip_di;
  assign ip_do_rdy = r_rdy;
  assign fb_req    = r_fb_req;
  assign fb_we     = r_fb_we;
  assign fb_addr   = r_fb_addr;
  assign fb_wdata  = r_fb_wdata;

  assign w_ptr_sel = (ip_addr == 8'h12) || (ip_addr == 8'h13) || (ip_addr == 8'h14);

  genvar gi;
  generate
    for (gi = 0; gi < ARG_REGS; gi++) begin : g_arg
      assign w_args[8*gi +: 8] = r_arg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_arg[gi] <= 8'h00;
        end else if (w_wr_ok && (ip_addr == 8'(gi))) begin
          r_arg[gi] <= ip_do;
        end
      end
    end

    // Each pointer bit takes its byte lane from whichever PTR byte address is being written.
    // Writes to bits at or above FB_AW therefore simply have no storage.
    for (gi = 0; gi < FB_AW; gi++) begin : g_ptr_bit
      localparam logic [7:0] BYTE_ADDR = 8'h12 + 8'(gi / 8);
      assign w_ptr_wdata[gi] = (ip_addr == BYTE_ADDR) ? ip_do[gi % 8] : r_ptr[gi];
    end
  endgenerate

  always_comb begin
    w_ptr24 = '0;
    w_ptr24[FB_AW-1:0] = r_ptr;
  end

  always_comb begin
    w_rd_val = 8'h00;
    for (int i = 0; i < ARG_REGS; i++) begin
      if (ip_addr == 8'(i)) w_rd_val = r_arg[i];
    end
    case (ip_addr)
      8'h10:   w_rd_val = r_last_opcode;
      8'h11:   w_rd_val = w_status;
      8'h12:   w_rd_val = w_ptr24[7:0];
      8'h13:   w_rd_val = w_ptr24[15:8];
      8'h14:   w_rd_val = w_ptr24[23:16];
      default: ;
    endcase
  end

  // Bridge / framebuffer sequencer.
  // Asserting reset mid-access drops fb_req at once, without waiting for fb_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rdy      <= 1'b1;
      r_ip_di    <= 8'h00;
      r_fb_req   <= 1'b0;
      r_fb_we    <= 1'b0;
      r_fb_addr  <= '0;
      r_fb_wdata <= 8'h00;
      r_ptr      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fb_start) begin
            r_state    <= S_FB_WAIT;
            r_rdy      <= 1'b0;
            r_fb_req   <= 1'b1;
            r_fb_addr  <= r_ptr;
            r_fb_we    <= ip_wr;
            r_fb_wdata <= ip_do;
          end else begin
            if (w_rd_ok) r_ip_di <= w_rd_val;
            if (w_wr_ok && w_ptr_sel) r_ptr <= w_ptr_wdata;
          end
        end
        S_FB_WAIT: begin
          if (fb_ack) begin
            r_state  <= S_IDLE;
            r_fb_req <= 1'b0;
            r_rdy    <= 1'b1;
            if (!r_fb_we) r_ip_di <= fb_rdata;
`ifdef EPP_GPU_REGS_AUTOINC_EN
            r_ptr <= r_ptr + PTR_ONE;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping, overflow flag and last opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= 5'd0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_last_opcode <= 8'h00;
    end else begin
      if (w_push) r_last_opcode <= ip_do;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_ONE;
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 5'd1;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - 5'd1;
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (w_wr_ok && (ip_addr == 8'h11) && ip_do[2]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Command storage: plain array with no reset, so it can map onto RAM.
  // It is read through the registered read pointer.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_op_mem[r_wr_ptr]   <= ip_do;
      r_args_mem[r_wr_ptr] <= w_args;
    end
  end

  // Parameter PTR_ONE is referenced only when auto-increment is built in.
  // FIFO_ONE keeps the pointer adds width-exact.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, PTR_ONE};

endmodule

// File: tb/tb_epp_gpu_regs.sv
// Self-checking bench for epp_gpu_regs at its default parameters (8 ARGs, 16-deep FIFO, FB_AW=19).
// It follows the build macro EPP_GPU_REGS_AUTOINC_EN so that the pointer expectations track the build.
module tb_epp_gpu_regs;

  localparam int FB_AW = 19;
`ifdef EPP_GPU_REGS_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       ip_addr = 8'h00;
  logic [7:0]       ip_do = 8'h00;
  logic             ip_wr = 1'b0;
  logic             ip_rd = 1'b0;
  logic [7:0]       ip_di;
  logic             ip_do_rdy;
  logic             cmd_valid;
  logic [7:0]       cmd_opcode;
  logic [63:0]      cmd_args;
  logic             cmd_ready = 1'b0;
  logic             gpu_busy = 1'b0;
  logic             fb_req;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_wdata;
  logic [7:0]       fb_rdata = 8'h00;
  logic             fb_ack = 1'b0;

  epp_gpu_regs #(.ARG_REGS(8), .FIFO_DEPTH(16), .FB_AW(FB_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ip_addr(ip_addr), .ip_do(ip_do), .ip_wr(ip_wr), .ip_rd(ip_rd),
    .ip_di(ip_di), .ip_do_rdy(ip_do_rdy),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_args(cmd_args),
    .cmd_ready(cmd_ready), .gpu_busy(gpu_busy),
    .fb_req(fb_req), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_rdata(fb_rdata), .fb_ack(fb_ack)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } sb_t;
  sb_t         sb_q[$];
  logic [7:0]  fifo_op_q[$];
  logic [63:0] fifo_arg_q[$];
  logic [63:0] m_args = 64'h0;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_pop_check(input logic [7:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0x%02h, expected nothing", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, {56'h0, act}, {56'h0, e.val});
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ip_addr = a; ip_do = d; ip_wr = 1'b1;
    @(negedge clk);
    ip_wr = 1'b0;
    if (a < 8'd8) m_args[8*a +: 8] = d;
    $display("wr addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    sb_t e;
    @(negedge clk);
    ip_addr = a; ip_rd = 1'b1;
    e.name = name; e.val = exp;
    sb_q.push_back(e);
    @(negedge clk);
    ip_rd = 1'b0;
    $display("rd addr=0x%02h data=0x%02h", a, ip_di);
    sb_pop_check(ip_di);
  endtask

  // FBDATA access with the ack returned 3 cycles after the request edge.
  // When inject is set, an ARG2 write is attempted while busy; it must be ignored.
  task automatic fb_access(input bit we, input logic [7:0] d, input logic [FB_AW-1:0] exp_addr,
                           input logic [7:0] rdata, input bit inject);
    sb_t e;
    @(negedge clk);
    ip_addr = 8'h15; ip_do = d; ip_wr = we; ip_rd = !we;
    if (!we) begin
      e.name = "fb_read_data"; e.val = rdata;
      sb_q.push_back(e);
    end
    @(negedge clk);
    ip_wr = 1'b0; ip_rd = 1'b0;
    check("fb_req_set", {63'h0, fb_req}, 64'h1);
    check("fb_we", {63'h0, fb_we}, {63'h0, we});
    check("fb_addr", {45'h0, fb_addr}, {45'h0, exp_addr});
    if (we) check("fb_wdata", {56'h0, fb_wdata}, {56'h0, d});
    check("rdy_low", {63'h0, ip_do_rdy}, 64'h0);
    if (inject) begin
      ip_addr = 8'h02; ip_do = 8'h99; ip_wr = 1'b1;
    end
    @(negedge clk);
    ip_wr = 1'b0;
    check("fb_addr_hold", {45'h0, fb_addr}, {45'h0, exp_addr});
    @(negedge clk);
    check("rdy_wait", {63'h0, ip_do_rdy}, 64'h0);
    fb_ack = 1'b1; fb_rdata = rdata;
    @(negedge clk);
    fb_ack = 1'b0;
    check("fb_req_clr", {63'h0, fb_req}, 64'h0);
    check("rdy_back", {63'h0, ip_do_rdy}, 64'h1);
    $display("fb %s addr=0x%05h data=0x%02h", we ? "wr" : "rd", exp_addr, we ? d : ip_di);
    if (!we) sb_pop_check(ip_di);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] old_di;

    vecs = '{
      '{1'b1, 8'h00, 8'h11, 8'h00}, '{1'b1, 8'h07, 8'h77, 8'h00},
      '{1'b1, 8'h03, 8'hA5, 8'h00}, '{1'b0, 8'h00, 8'h00, 8'h11},
      '{1'b0, 8'h07, 8'h00, 8'h77}, '{1'b0, 8'h03, 8'h00, 8'hA5},
      '{1'b0, 8'h02, 8'h00, 8'h00}, '{1'b1, 8'h08, 8'hFF, 8'h00},
      '{1'b0, 8'h08, 8'h00, 8'h00}, '{1'b0, 8'h20, 8'h00, 8'h00},
      '{1'b1, 8'h12, 8'h34, 8'h00}, '{1'b0, 8'h12, 8'h00, 8'h34},
      '{1'b1, 8'h13, 8'h56, 8'h00}, '{1'b0, 8'h13, 8'h00, 8'h56},
      '{1'b1, 8'h14, 8'hFF, 8'h00}, '{1'b0, 8'h14, 8'h00, 8'h07},
      '{1'b1, 8'h3F, 8'h12, 8'h00}, '{1'b0, 8'h11, 8'h00, 8'h01}
    };

    // 1: reset state, then an FBDATA read.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", {63'h0, ip_do_rdy}, 64'h1);
    check("rst_cmd_valid", {63'h0, cmd_valid}, 64'h0);
    check("rst_fb_req", {63'h0, fb_req}, 64'h0);
    check("rst_fb_we", {63'h0, fb_we}, 64'h0);
    check("rst_ip_di", {56'h0, ip_di}, 64'h0);
    reg_read(8'h11, 8'h01, "status_after_reset");
    fb_access(1'b0, 8'h00, 19'h00000, 8'hA5, 1'b0);
    reg_read(8'h12, AUTOINC ? 8'h01 : 8'h00, "ptr_after_fb_read");

    // Table: ARG/PTR R/W, unmapped addresses, PTR high-bit masking.
    foreach (vecs[i]) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
      else reg_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd_0x%02h", i, vecs[i].addr));
    end

    // 2: single CMD push, head contents, drain.
    reg_write(8'h10, 8'h42);
    check("cmd_valid", {63'h0, cmd_valid}, 64'h1);
    check("cmd_opcode", {56'h0, cmd_opcode}, 64'h42);
    check("cmd_arg0", {56'h0, cmd_args[7:0]}, 64'h11);
    check("cmd_arg7", {56'h0, cmd_args[63:56]}, 64'h77);
    check("cmd_args_all", cmd_args, m_args);
    reg_read(8'h11, 8'h10, "status_one_entry");
    reg_read(8'h10, 8'h42, "last_opcode");
    @(negedge clk); cmd_ready = 1'b1;
    @(negedge clk); cmd_ready = 1'b0;
    check("cmd_valid_after_pop", {63'h0, cmd_valid}, 64'h0);
    reg_read(8'h11, 8'h01, "status_drained");

    // 3: overflow, sticky clear, full push with a same-cycle pop.
    for (int i = 0; i < 17; i++) begin
      reg_write(8'h10, 8'h80 + 8'(i));
      if (i < 16) begin
        fifo_op_q.push_back(8'h80 + 8'(i));
        fifo_arg_q.push_back(m_args);
      end
    end
    reg_read(8'h11, 8'hF6, "status_overflow_full");
    reg_read(8'h10, 8'h90, "last_opcode_dropped");
    reg_write(8'h11, 8'h04);
    reg_read(8'h11, 8'hF2, "status_overflow_cleared");
    @(negedge clk);
    ip_addr = 8'h10; ip_do = 8'hC3; ip_wr = 1'b1; cmd_ready = 1'b1;
    check("head_before_pop", {56'h0, cmd_opcode}, {56'h0, fifo_op_q.pop_front()});
    void'(fifo_arg_q.pop_front());
    fifo_op_q.push_back(8'hC3);
    fifo_arg_q.push_back(m_args);
    @(negedge clk);
    ip_wr = 1'b0; cmd_ready = 1'b0;
    $display("wr addr=0x10 data=0xC3 with pop");
    reg_read(8'h11, 8'hF2, "status_full_push_pop");
    @(negedge clk);
    cmd_ready = 1'b1;
    for (int k = 0; k < 40 && fifo_op_q.size() > 0; k++) begin
      if (!cmd_valid) break;
      check("drain_opcode", {56'h0, cmd_opcode}, {56'h0, fifo_op_q.pop_front()});
      check("drain_args", cmd_args, fifo_arg_q.pop_front());
      @(negedge clk);
    end
    cmd_ready = 1'b0;
    check("drain_remaining", 64'(fifo_op_q.size()), 64'h0);
    check("drain_cmd_valid", {63'h0, cmd_valid}, 64'h0);
    gpu_busy = 1'b1;
    reg_read(8'h11, 8'h09, "status_gpu_busy");
    gpu_busy = 1'b0;

    // 4: PTR wrap on FBDATA writes; an access while busy is ignored.
    reg_write(8'h12, 8'hFF);
    reg_write(8'h13, 8'hFF);
    reg_write(8'h14, 8'hFF);
    reg_read(8'h14, 8'h07, "ptr_high_masked");
    fb_access(1'b1, 8'hDE, 19'h7FFFF, 8'h00, 1'b1);
    fb_access(1'b1, 8'hAD, AUTOINC ? 19'h00000 : 19'h7FFFF, 8'h00, 1'b0);
    reg_read(8'h02, 8'h00, "arg2_busy_write_ignored");
    reg_read(8'h12, AUTOINC ? 8'h01 : 8'hFF, "ptr_low_after_wrap");
    reg_read(8'h14, AUTOINC ? 8'h00 : 8'h07, "ptr_high_after_wrap");
    old_di = ip_di;
    @(negedge clk); fb_ack = 1'b1; fb_rdata = 8'h3C;
    @(negedge clk); fb_ack = 1'b0;
    check("idle_ack_ip_di", {56'h0, ip_di}, {56'h0, old_di});
    check("idle_ack_rdy", {63'h0, ip_do_rdy}, 64'h1);
    reg_read(8'h12, AUTOINC ? 8'h01 : 8'hFF, "ptr_after_idle_ack");

    // 6: simultaneous write+read, where the write wins.
    old_di = ip_di;
    @(negedge clk);
    ip_addr = 8'h01; ip_do = 8'h5C; ip_wr = 1'b1; ip_rd = 1'b1;
    @(negedge clk);
    ip_wr = 1'b0; ip_rd = 1'b0;
    m_args[15:8] = 8'h5C;
    $display("wr+rd addr=0x01 data=0x5C");
    check("wr_rd_ip_di", {56'h0, ip_di}, {56'h0, old_di});
    check("wr_rd_rdy", {63'h0, ip_do_rdy}, 64'h1);
    reg_read(8'h01, 8'h5C, "arg1_write_wins");

    // 5: reset in the middle of an FBDATA access.
    @(negedge clk);
    ip_addr = 8'h15; ip_rd = 1'b1;
    @(negedge clk);
    ip_rd = 1'b0;
    check("pre_reset_fb_req", {63'h0, fb_req}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("reset_fb_req", {63'h0, fb_req}, 64'h0);
    check("reset_rdy", {63'h0, ip_do_rdy}, 64'h1);
    check("reset_ip_di", {56'h0, ip_di}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_args = 64'h0;
    fb_ack = 1'b1; fb_rdata = 8'hEE;
    @(negedge clk);
    fb_ack = 1'b0;
    $display("reset during fb access, late ack");
    check("late_ack_fb_req", {63'h0, fb_req}, 64'h0);
    check("late_ack_ip_di", {56'h0, ip_di}, 64'h0);
    reg_read(8'h12, 8'h00, "ptr_low_after_reset");
    reg_read(8'h13, 8'h00, "ptr_mid_after_reset");
    reg_read(8'h14, 8'h00, "ptr_high_after_reset");
    reg_read(8'h00, 8'h00, "arg0_after_reset");
    reg_read(8'h11, 8'h01, "status_after_mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
